// File: rtl/cordic_input_stage.sv
`default_nettype none
// ============================================================================
// Module   : cordic_input_stage
// Purpose  : Registered, flow-controlled front end for the CORDIC core.
//            Folds rotation angles / arctan vectors into the core's +/-90 deg
//            convergence range, emits a flip code for the output stage, and
//            buffers folded requests in a DEPTH-entry circular FIFO.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            in_valid/in_ready     - request handshake
//            in_mode               - 0 = rotation, 1 = arctan
//            in_degree, in_x, in_y - request operands (signed)
//            out_valid/out_ready   - folded request handshake
//            out_mode, out_degree, out_x, out_y, out_flip - FIFO head
//            level                 - FIFO occupancy
//            range_err             - out-of-range pulse (macro builds only)
// Options  : CORDIC_INPUT_RANGE_CHECK_EN - drop out-of-range requests and
//            pulse range_err instead of folding them.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_input_stage #(
   parameter int INPUT_WIDTH      = 16,
   parameter int ANGLE_FRAC_WIDTH = 0,
   parameter int XY_FRAC_WIDTH    = 8,
   parameter int DEPTH            = 4,
   parameter int FLIP_FLAG_WIDTH  = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_mode,
   input  logic [INPUT_WIDTH-1:0]       in_degree,
   input  logic [INPUT_WIDTH-1:0]       in_x,
   input  logic [INPUT_WIDTH-1:0]       in_y,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_mode,
   output logic [INPUT_WIDTH-1:0]       out_degree,
   output logic [INPUT_WIDTH-1:0]       out_x,
   output logic [INPUT_WIDTH-1:0]       out_y,
   output logic [FLIP_FLAG_WIDTH-1:0]   out_flip,
   output logic [$clog2(DEPTH):0]       level
`ifdef CORDIC_INPUT_RANGE_CHECK_EN
   ,
   output logic                         range_err
`endif
);

   localparam int W  = INPUT_WIDTH;
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   // Angle constants are held at W+1 bits so the fold arithmetic cannot wrap.
   localparam logic signed [W:0] C_P90   = (W+1)'(90  * (2 ** ANGLE_FRAC_WIDTH));
   localparam logic signed [W:0] C_P180  = (W+1)'(180 * (2 ** ANGLE_FRAC_WIDTH));
   localparam logic signed [W:0] C_M90   = -C_P90;
   localparam logic signed [W:0] C_SMAX  = {2'b00, {(W-1){1'b1}}};
   localparam logic [W-1:0]      C_ONE   = {{(W-1){1'b0}}, 1'b1} << XY_FRAC_WIDTH;
   localparam logic [LW-1:0]     C_DEPTH = LW'(DEPTH);

   // Two's-complement negate at W+1 bits; only -MIN exceeds the positive range.
   function automatic logic [W-1:0] neg_sat(input logic [W-1:0] v);
      logic signed [W:0] n;
      n = -$signed({v[W-1], v});
      if (n > C_SMAX) begin
         return C_SMAX[W-1:0];
      end
      return n[W-1:0];
   endfunction

   // ---------------------------------------------------------------- fold
   logic signed [W:0]          w_d_ext;
   logic signed [W:0]          w_d_sum;
   logic [W-1:0]               w_fold_deg;
   logic [W-1:0]               w_fold_x;
   logic [W-1:0]               w_fold_y;
   logic [FLIP_FLAG_WIDTH-1:0] w_fold_flip;

   always_comb begin
      w_d_ext     = {in_degree[W-1], in_degree};
      w_d_sum     = w_d_ext;
      w_fold_deg  = '0;
      w_fold_x    = in_x;
      w_fold_y    = in_y;
      w_fold_flip = '0;
      if (!in_mode) begin
         if (w_d_ext > C_P90) begin
            w_d_sum        = w_d_ext - C_P180;
            w_fold_flip[0] = 1'b1;
         end else if (w_d_ext < C_M90) begin
            w_d_sum        = w_d_ext + C_P180;
            w_fold_flip[0] = 1'b1;
         end
         w_fold_deg = w_d_sum[W-1:0];
         w_fold_x   = C_ONE;
         w_fold_y   = '0;
      end else begin
         w_fold_flip[1] = in_y[W-1];
         if (in_x[W-1]) begin
            w_fold_x       = neg_sat(in_x);
            w_fold_y       = neg_sat(in_y);
            w_fold_flip[0] = 1'b1;
         end
      end
   end

   // ----------------------------------------------------------- handshake
   logic [LW-1:0] level_q, level_d;
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic          w_push;
   logic          w_write;
   logic          w_pop;

   assign in_ready  = (level_q < C_DEPTH);
   assign out_valid = (level_q != '0);
   assign level     = level_q;
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

`ifdef CORDIC_INPUT_RANGE_CHECK_EN
   localparam logic signed [W:0] C_M180 = -C_P180;
   logic w_bad;
   logic range_err_q;

   // Out-of-range requests are consumed but never enter the FIFO.
   assign w_bad     = in_mode ? ((in_x == '0) && (in_y == '0))
                              : ((w_d_ext > C_P180) || (w_d_ext < C_M180));
   assign w_write   = w_push && !w_bad;
   assign range_err = range_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         range_err_q <= 1'b0;
      end else begin
         range_err_q <= w_push && w_bad;
      end
   end
`else
   assign w_write = w_push;
`endif

   always_comb begin
      level_d = level_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      if (w_write) begin
         wr_d = wr_q + PW'(1);
      end
      if (w_pop) begin
         rd_d = rd_q + PW'(1);
      end
      if (w_write && !w_pop) begin
         level_d = level_q + LW'(1);
      end else if (!w_write && w_pop) begin
         level_d = level_q - LW'(1);
      end
   end

   // ------------------------------------------------------------- storage
   logic                       mode_mem_q [DEPTH];
   logic [W-1:0]               deg_mem_q  [DEPTH];
   logic [W-1:0]               x_mem_q    [DEPTH];
   logic [W-1:0]               y_mem_q    [DEPTH];
   logic [FLIP_FLAG_WIDTH-1:0] flip_mem_q [DEPTH];

   // Entries are cleared on reset so the head reads as zero afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mode_mem_q[i] <= 1'b0;
            deg_mem_q[i]  <= '0;
            x_mem_q[i]    <= '0;
            y_mem_q[i]    <= '0;
            flip_mem_q[i] <= '0;
         end
      end else begin
         level_q <= level_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         if (w_write) begin
            mode_mem_q[wr_q] <= in_mode;
            deg_mem_q[wr_q]  <= w_fold_deg;
            x_mem_q[wr_q]    <= w_fold_x;
            y_mem_q[wr_q]    <= w_fold_y;
            flip_mem_q[wr_q] <= w_fold_flip;
         end
      end
   end

   assign out_mode   = mode_mem_q[rd_q];
   assign out_degree = deg_mem_q[rd_q];
   assign out_x      = x_mem_q[rd_q];
   assign out_y      = y_mem_q[rd_q];
   assign out_flip   = flip_mem_q[rd_q];

endmodule
`default_nettype wire

// File: tb/tb_cordic_input_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_input_stage
// Purpose  : Self-checking bench for cordic_input_stage: fold vector table,
//            FIFO full/drain, concurrent push/pop across pointer wrap,
//            mid-stream reset, optional range check, and randomized traffic
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_input_stage;

   localparam int W     = 16;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic          in_mode;
   logic [W-1:0]  in_degree, in_x, in_y;
   logic          out_valid;
   logic          out_ready;
   logic          out_mode;
   logic [W-1:0]  out_degree, out_x, out_y;
   logic [1:0]    out_flip;
   logic [2:0]    level;
`ifdef CORDIC_INPUT_RANGE_CHECK_EN
   logic          range_err;
`endif

   always #5 clk = ~clk;

   cordic_input_stage dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_mode    (in_mode),
      .in_degree  (in_degree),
      .in_x       (in_x),
      .in_y       (in_y),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_mode   (out_mode),
      .out_degree (out_degree),
      .out_x      (out_x),
      .out_y      (out_y),
      .out_flip   (out_flip),
      .level      (level)
`ifdef CORDIC_INPUT_RANGE_CHECK_EN
      ,
      .range_err  (range_err)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        mode;
      logic [15:0] deg, x, y;
      logic [1:0]  flip;
   } ent_t;

   typedef struct {
      ent_t stim;
      ent_t exp;
   } vec_t;

   vec_t tbl[$];
   ent_t q[$];

   task automatic add_vec(input bit m, input int d, input int x, input int y,
                          input int ed, input int ex, input int ey, input int ef);
      vec_t v;
      v.stim.mode = m;  v.stim.deg = 16'(d);  v.stim.x = 16'(x);  v.stim.y = 16'(y);
      v.stim.flip = 2'b00;
      v.exp.mode  = m;  v.exp.deg  = 16'(ed); v.exp.x  = 16'(ex); v.exp.y  = 16'(ey);
      v.exp.flip  = 2'(ef);
      tbl.push_back(v);
   endtask

   // Reference fold computed with plain integer arithmetic.
   function automatic ent_t model(input bit m, input int d, input int x, input int y);
      ent_t e;
      int fd, fx, fy;
      bit f0, f1;
      fd = d; fx = x; fy = y; f0 = 0; f1 = 0;
      if (!m) begin
         if (d > 90) begin fd = d - 180; f0 = 1; end
         else if (d < -90) begin fd = d + 180; f0 = 1; end
         fx = 256;
         fy = 0;
      end else begin
         fd = 0;
         f1 = (y < 0);
         if (x < 0) begin fx = -x; fy = -y; f0 = 1; end
         if (fx > 32767) fx = 32767;
         if (fy > 32767) fy = 32767;
      end
      e.mode = m; e.deg = 16'(fd); e.x = 16'(fx); e.y = 16'(fy); e.flip = {f1, f0};
      return e;
   endfunction

   task automatic check_head(input string tag, input ent_t e);
      check({tag, ".mode"}, 32'(out_mode),   32'(e.mode));
      check({tag, ".deg"},  32'(out_degree), 32'(e.deg));
      check({tag, ".x"},    32'(out_x),      32'(e.x));
      check({tag, ".y"},    32'(out_y),      32'(e.y));
      check({tag, ".flip"}, 32'(out_flip),   32'(e.flip));
   endtask

   initial begin
      int   eq[$];
      ent_t e;
      int   di, xi, yi;
      bit   push, pop, bad;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_mode = 1'b0;
      in_degree = '0; in_x = '0; in_y = '0;
      tick();
      tick();
      check("rst.level",     32'(level),      0);
      check("rst.out_valid", 32'(out_valid),  0);
      check("rst.in_ready",  32'(in_ready),   1);
      check("rst.degree",    32'(out_degree), 0);
      check("rst.flip",      32'(out_flip),   0);
      rst = 1'b0;
      tick();

      // ---------------------------------------------------- fold table
      add_vec(0,  120, 0, 0,  -60, 256, 0, 1);
      add_vec(0,  -90, 0, 0,  -90, 256, 0, 0);
      add_vec(0,  -91, 0, 0,   89, 256, 0, 1);
      add_vec(0,   90, 0, 0,   90, 256, 0, 0);
      add_vec(0,  180, 0, 0,    0, 256, 0, 1);
      add_vec(0, -180, 0, 0,    0, 256, 0, 1);
      add_vec(0,    0, 0, 0,    0, 256, 0, 0);
      add_vec(1,   77, -32'h200, -32'h80, 0, 32'h200, 32'h80, 3);
      add_vec(1,    0, 32'h8000, 32'h10, 0, 32'h7FFF, -32'h10, 1);
      add_vec(1,    0, 32'h100, -5, 0, 32'h100, -5, 2);
      add_vec(1,    0, -1, 32'h8000, 0, 1, 32'h7FFF, 3);
      add_vec(1,    0, 32'h7FFF, 32'h1234, 0, 32'h7FFF, 32'h1234, 0);

      out_ready = 1'b1;
      foreach (tbl[i]) begin
         in_mode = tbl[i].stim.mode; in_degree = tbl[i].stim.deg;
         in_x = tbl[i].stim.x; in_y = tbl[i].stim.y;
         in_valid = 1'b1;
         tick();
         check($sformatf("tbl%0d.valid", i), 32'(out_valid), 1);
         check_head($sformatf("tbl%0d", i), tbl[i].exp);
         in_valid = 1'b0;
         tick();
         check($sformatf("tbl%0d.level", i), 32'(level), 0);
      end

      // ---------------------------------------------------- fill / drain
      out_ready = 1'b0; in_mode = 1'b0; in_x = '0; in_y = '0;
      for (int i = 0; i < DEPTH; i++) begin
         in_degree = 16'(10 * (i + 1));
         in_valid = 1'b1;
         tick();
         check("fill.level", 32'(level), 32'(i + 1));
      end
      check("full.in_ready", 32'(in_ready), 0);
      in_degree = 16'd50;
      tick();
      check("full.level", 32'(level), DEPTH);
      check("full.head", 32'(out_degree), 10);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         check("drain.valid", 32'(out_valid), 1);
         check("drain.order", 32'(out_degree), 32'(10 * (i + 1)));
         tick();
         check("drain.level", 32'(level), 32'(DEPTH - 1 - i));
         if (i == 0) check("drain.in_ready", 32'(in_ready), 1);
      end
      check("drain.empty", 32'(out_valid), 0);

      // ---------------------------------------------------- concurrent
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_degree = 16'd1; tick();
      in_degree = 16'd2; tick();
      eq.push_back(1); eq.push_back(2);
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_degree = 16'(3 + k);
         tick();
         void'(eq.pop_front());
         eq.push_back(3 + k);
         check("conc.level", 32'(level), 2);
         check("conc.order", 32'(out_degree), 32'(eq[0]));
      end
      rst = 1'b1;
      tick();
      check("mrst.level",    32'(level),      0);
      check("mrst.valid",    32'(out_valid),  0);
      check("mrst.in_ready", 32'(in_ready),   1);
      check("mrst.degree",   32'(out_degree), 0);
      check("mrst.x",        32'(out_x),      0);
      check("mrst.flip",     32'(out_flip),   0);
      rst = 1'b0;
      in_valid = 1'b0;
      tick();
      check("mrst.after", 32'(level), 0);

`ifdef CORDIC_INPUT_RANGE_CHECK_EN
      // ---------------------------------------------------- range check
      out_ready = 1'b0; in_mode = 1'b0; in_degree = 16'd200; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("rng.err",   32'(range_err), 1);
      check("rng.level", 32'(level),     0);
      check("rng.valid", 32'(out_valid), 0);
      tick();
      check("rng.pulse", 32'(range_err), 0);
`endif

      // ---------------------------------------------------- random
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_mode   = 1'($urandom_range(0, 1));
         di        = int'($urandom_range(0, 360)) - 180;
         in_degree = 16'(di);
         in_x      = 16'($urandom);
         in_y      = 16'($urandom);
         if ($urandom_range(0, 15) == 0) in_x = 16'h8000;
         if ($urandom_range(0, 15) == 0) in_y = 16'h8000;
         xi = int'($signed(in_x));
         yi = int'($signed(in_y));
         check("rnd.in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
         push = in_valid && (q.size() < DEPTH);
         pop  = (q.size() != 0) && out_ready;
         bad  = 1'b0;
`ifdef CORDIC_INPUT_RANGE_CHECK_EN
         bad  = in_mode ? (xi == 0 && yi == 0) : (di > 180 || di < -180);
`endif
         e = model(in_mode, di, xi, yi);
         tick();
         if (pop) void'(q.pop_front());
         if (push && !bad) q.push_back(e);
`ifdef CORDIC_INPUT_RANGE_CHECK_EN
         check("rnd.range_err", 32'(range_err), 32'(push && bad));
`endif
         check("rnd.level", 32'(level),     32'(q.size()));
         check("rnd.valid", 32'(out_valid), 32'(q.size() != 0));
         if (q.size() != 0) check_head("rnd", q[0]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cordic_input_stage.md
# cordic_input_stage

Registered, flow-controlled front end for the CORDIC core. It accepts rotation requests (angle) or arctan requests (x, y) through a valid/ready handshake. Each request is folded into the core's convergence range of ±90°, and a flip code is emitted that the output stage uses to undo the fold. A DEPTH-entry FIFO sits between the folding logic and the core so the core can stall without dropping samples.

## Interface
- INPUT_WIDTH, 16, width of the angle, x and y operands (signed two's complement)
- ANGLE_FRAC_WIDTH, 0, fractional bits of the angle; 90° is encoded as 90 << ANGLE_FRAC_WIDTH
- XY_FRAC_WIDTH, 8, fractional bits of x/y; unit value is 1 << XY_FRAC_WIDTH
- DEPTH, 4, number of FIFO entries, a power of two ≥ 2
- FLIP_FLAG_WIDTH, 2, width of the flip code

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  stage can accept a request
- in_mode  in  1  0 = rotation, 1 = arctan
- in_degree  in  INPUT_WIDTH  signed angle, legal range −180°..+180°; used only when in_mode = 0
- in_x, in_y  in  INPUT_WIDTH  signed vector; used only when in_mode = 1
- out_valid  out  1  folded request available
- out_ready  in  1  core accepts the request
- out_mode  out  1  mode carried through from in_mode
- out_degree  out  INPUT_WIDTH  folded angle
- out_x, out_y  out  INPUT_WIDTH  folded vector
- out_flip  out  FLIP_FLAG_WIDTH  bit0 = fold applied; bit1 = sign of the original y (arctan mode only, else 0)
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- range_err  out  1  one-cycle pulse marking an out-of-range request (present only with the macro)

## Operation
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (level < DEPTH). in_ready is independent of out_ready and is not a combinational path.
- Rotation fold, with P90 = 90° and P180 = 180° in ANGLE_FRAC_WIDTH scaling:
  - d > P90: degree = d − P180, flip[0] = 1
  - d < −P90: degree = d + P180, flip[0] = 1
  - otherwise: degree passes unchanged, flip[0] = 0
  - In all cases x = 1 << XY_FRAC_WIDTH, y = 0.
  - d = ±P90 is not folded.
- Arctan fold:
  - x < 0: out_x = −x, out_y = −y, flip[0] = 1
  - otherwise: x and y pass unchanged, flip[0] = 0
  - flip[1] = y[MSB] of the original y; out_degree = 0.
- Width rules:
  - Folding arithmetic is done at INPUT_WIDTH+1 bits, then truncated; legal inputs never overflow.
  - Negating the most-negative value saturates to the maximum positive value.
- FIFO: circular buffer with read and write pointers of $clog2(DEPTH) bits, wrapping from DEPTH−1 to 0. The occupancy counter is level.
- Push and pop in the same cycle: level is unchanged and both pointers advance. This is legal at any level below DEPTH. When full, no push can occur, so only the pop happens.
- Outputs are driven from the FIFO head register. They are stable while out_valid && !out_ready.

## Timing
- Latency: a request pushed in cycle N appears with out_valid = 1 in cycle N+1 if the FIFO was empty.
- Throughput: 1 request per cycle while out_ready = 1.
- in_ready falls in the cycle after the push that makes level = DEPTH. It rises in the cycle after the pop that frees an entry.
- Reset (sync, active-high), applied at any time including mid-transfer:
  - level = 0, pointers = 0, out_valid = 0, in_ready = 1 in the cycle after rst is sampled
  - out_degree, out_x, out_y, out_flip, out_mode = 0; range_err = 0
  - FIFO contents are discarded; no partial transfer survives reset.
- rst has priority over push and pop in the same cycle.

## Configuration
- Macro: CORDIC_INPUT_RANGE_CHECK_EN.
- Defined:
  - A rotation request with d > P180 or d < −P180 is handshaken (consumed) but not written to the FIFO; level does not change.
  - range_err pulses high for the cycle after the push.
  - Arctan requests with x = y = 0 are treated the same way.
- Undefined:
  - No range_err port.
  - Every request is folded by the rules above, and out-of-range results are unspecified.

## Test plan
- Rotation, in_degree = 120, out_ready = 1 → next cycle out_degree = −60, out_flip = 2'b01, out_x = 0x0100, out_y = 0.
- Rotation, in_degree = −90, then −91 → out_degree = −90 with flip 2'b00, then +89 with flip 2'b01.
- Arctan, in_x = −0x0200, in_y = −0x0080 → out_x = 0x0200, out_y = 0x0080, out_flip = 2'b11; also in_x = 0x8000 → out_x = 0x7FFF.
- Hold out_ready = 0 and push 4 requests (DEPTH = 4) → level = 4, in_ready = 0; raise out_ready → the 4 requests pop in order, one per cycle.
- Concurrent push and pop at level = 2 for 10 cycles → level stays 2 and data order is preserved across pointer wrap. Assert rst mid-stream → the next cycle shows level = 0, out_valid = 0, in_ready = 1.
- With CORDIC_INPUT_RANGE_CHECK_EN, in_degree = 200 → range_err pulses for 1 cycle, level unchanged, out_valid stays 0.
